multi_cycle_core: RTL
=====================

# multi_cycle_core

Parametrised multi-cycle successor to the single-cycle SEQ processor top.

- Executes an RV32I/RV64I subset through an FSM with one stage per cycle, so per-instruction latency depends on the instruction class.
- Contains its own instruction memory, data memory and register file.
- Instruction memory is loaded through a host port; the core runs from a `start` pulse until `ebreak` or an illegal opcode.
- Debug read ports expose register and data-memory contents to the bench.

## Interface
- XLEN, 64: datapath and register width; 32 or 64.
- IMEM_WORDS, 64: instruction memory depth in 32-bit words; power of 2.
- DMEM_WORDS, 32: data memory depth in XLEN-bit words; power of 2.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin execution at PC 0; honoured only in IDLE or HALT.
- imem_we  in  1  instruction memory write enable; ignored while busy.
- imem_addr  in  $clog2(IMEM_WORDS)  instruction word index.
- imem_wdata  in  32  instruction word.
- dbg_reg_addr  in  5  register debug read index.
- dbg_reg_data  out  XLEN  combinational read of x[dbg_reg_addr]; x0 reads 0.
- dbg_mem_addr  in  $clog2(DMEM_WORDS)  data memory debug read index.
- dbg_mem_data  out  XLEN  combinational read of dmem[dbg_mem_addr].
- busy  out  1  high in FETCH, DECODE, EXEC, MEM and WB.
- halted  out  1  high in HALT.
- illegal  out  1  set when the halt was caused by an unsupported encoding.
- retired  out  1  one-cycle pulse on the final cycle of each completed instruction.
- pc_out  out  XLEN  byte PC of the current or last instruction.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE or HALT with `start` → FETCH. On this transition: PC=0, `halted`=0, `illegal`=0. Registers and dmem are preserved.
- FETCH: IR ← imem[(PC>>2) mod IMEM_WORDS].
- DECODE:
  - Latch rs1 data, rs2 data and the sign-extended immediate (I, S or B format).
  - `ebreak` (0x00100073) retires here, then → HALT.
  - Unsupported encoding → HALT with `illegal`=1. It does not retire; PC stays on the faulting instruction.
- EXEC: ALU result is latched.
  - R-type (0110011): add, sub, and, or, slt; funct7b5 selects sub.
  - addi (0010011, funct3 000).
  - Load/store address is rs1+imm.
  - beq/bne (1100011, funct3 000/001): retires here. Taken: PC ← PC+imm. Not taken: PC ← PC+4.
- MEM:
  - Load (0000011): MDR ← dmem[(addr>>log2(XLEN/8)) mod DMEM_WORDS]. Low address bits are ignored; addresses wrap.
  - Store (0100011): dmem[...] ← rs2. Store retires here.
- WB: rd ← ALU result or MDR. Writes to x0 are discarded. PC ← PC+4 and the instruction retires.
- Funct3 rules:
  - Loads and stores accept only the width matching XLEN: 011 for 64, 010 for 32. Other funct3 → illegal.
  - Unlisted R-type funct3/funct7 combinations → illegal.
- Arithmetic is modulo 2^XLEN. slt is signed. PC wraps modulo IMEM_WORDS*4 for fetch.

## Timing
- Cycles per instruction: ebreak 2, branch 3, ALU/addi 4, store 4, load 5.
- A write to rd is visible on `dbg_reg_data` the cycle after WB. A store is visible on `dbg_mem_data` the cycle after MEM.
- Reset values: state IDLE, PC 0, `busy` 0, `halted` 0, `illegal` 0, `retired` 0, `pc_out` 0, x1–x31 = 0.
- dmem and imem are not reset.
- `rst` has priority over every write. Reset asserted on a MEM or WB edge suppresses that store or register write.
- `start` while busy is ignored. `imem_we` while busy is ignored.
- `imem_we` and `start` in the same cycle while IDLE: the write completes, and the first FETCH sees the written word.

## Configuration
- MULTI_CYCLE_CORE_TRACE_EN:
  - Defined: on every `retired` pulse, `$display` prints the PC, the instruction, and x0–x9.
  - Undefined: no `$display`.
  - RTL behaviour and ports are identical in both cases.

## Test plan
- **Straight-line program.**
  - Program: addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; sd x3,0(x0); ld x4,8(x0)... sd x3,8(x0) then ld x4,8(x0); ebreak. XLEN=64.
  - Required: x3=12, x4=12, dmem[1]=12, 7 retire pulses, `busy` high exactly 4+4+4+4+4+5+2=27 cycles, `halted`=1, `illegal`=0.
- **Loop.**
  - Program: addi x1,x0,3; bne-loop of addi x1,x1,-1 and bne x1,x0,-4; ebreak.
  - Required: x1=0, 8 retire pulses, final `pc_out`=12.
- **Illegal opcode.**
  - Stimulus: word 0x0000007F at PC 4.
  - Required: `halted`=1, `illegal`=1, `pc_out`=4, no register change, retire count 1.
- **x0 and slt.**
  - Program: addi x0,x0,9; addi x5,x0,-1; slt x6,x5,x0.
  - Required: x0=0, x6=1, x5=0xFFFF_FFFF_FFFF_FFFF.
- **Reset during a store.**
  - Stimulus: assert `rst` on the MEM edge of sd x1,0(x0) with x1=77 and dmem[0] preloaded as 0.
  - Required: dmem[0] stays 0, all outputs at reset values the next cycle, registers cleared.
- **Restart from HALT.**
  - Stimulus: reload imem, then pulse `start`.
  - Required: `halted` and `illegal` clear, fetch restarts at PC 0, registers retain their prior values.

Source files
------------

// File: rtl/multi_cycle_core_if.sv
// Host/debug bus of multi_cycle_core: imem load, start, status and debug read ports.
interface multi_cycle_core_if #(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned IMEM_WORDS = 64,
   parameter int unsigned DMEM_WORDS = 32
);
   localparam int unsigned IAW = $clog2(IMEM_WORDS);
   localparam int unsigned DAW = $clog2(DMEM_WORDS);

   logic            start;
   logic            imem_we;
   logic [IAW-1:0]  imem_addr;
   logic [31:0]     imem_wdata;
   logic [4:0]      dbg_reg_addr;
   logic [XLEN-1:0] dbg_reg_data;
   logic [DAW-1:0]  dbg_mem_addr;
   logic [XLEN-1:0] dbg_mem_data;
   logic            busy;
   logic            halted;
   logic            illegal;
   logic            retired;
   logic [XLEN-1:0] pc_out;

   modport master (
      output start, imem_we, imem_addr, imem_wdata, dbg_reg_addr, dbg_mem_addr,
      input  dbg_reg_data, dbg_mem_data, busy, halted, illegal, retired, pc_out
   );

   modport slave (
      input  start, imem_we, imem_addr, imem_wdata, dbg_reg_addr, dbg_mem_addr,
      output dbg_reg_data, dbg_mem_data, busy, halted, illegal, retired, pc_out
   );
endinterface

// File: rtl/multi_cycle_core.sv
// Multi-cycle RV32I/RV64I subset core with private imem, dmem and register file.
// Optional retire trace: define MULTI_CYCLE_CORE_TRACE_EN.
module multi_cycle_core #(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned IMEM_WORDS = 64,
   parameter int unsigned DMEM_WORDS = 32
) (
   input logic                clk,
   input logic                rst,
   multi_cycle_core_if.slave  bus_io
);
   localparam int unsigned IAW  = $clog2(IMEM_WORDS);
   localparam int unsigned DAW  = $clog2(DMEM_WORDS);
   localparam int unsigned BOFF = $clog2(XLEN / 8);
   localparam logic [2:0]  LS_F3     = (XLEN == 64) ? 3'b011 : 3'b010;
   localparam logic [6:0]  OP_R      = 7'b0110011;
   localparam logic [6:0]  OP_IMM    = 7'b0010011;
   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [31:0] EBREAK    = 32'h0010_0073;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_e;

   typedef enum logic [2:0] {
      C_ALU, C_ADDI, C_LOAD, C_STORE, C_BRANCH, C_EBREAK, C_ILLEGAL
   } cls_e;

   typedef enum logic [2:0] {
      A_ADD, A_SUB, A_AND, A_OR, A_SLT
   } alu_e;

   state_e          state_q, state_d;
   logic [31:0]     ir_q;
   logic [XLEN-1:0] pc_q, a_q, b_q, imm_q, alu_q, mdr_q;
   logic            illegal_q;
   logic [31:0]     imem_q [IMEM_WORDS];
   logic [XLEN-1:0] dmem_q [DMEM_WORDS];
   logic [XLEN-1:0] rf_q   [32];

   logic [6:0]      opcode, funct7;
   logic [2:0]      funct3;
   logic [4:0]      rd, rs1, rs2;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_c;
   logic [XLEN-1:0] rs1_val, rs2_val, op_b, alu_res, pc_plus4;
   logic            busy_c, retired_c, taken_c;
   cls_e            cls_c;
   alu_e            alu_op_c;

   assign opcode  = ir_q[6:0];
   assign rd      = ir_q[11:7];
   assign funct3  = ir_q[14:12];
   assign rs1     = ir_q[19:15];
   assign rs2     = ir_q[24:20];
   assign funct7  = ir_q[31:25];
   assign imm_i   = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
   assign imm_s   = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
   assign imm_b   = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
   assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
   assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];
   assign pc_plus4 = pc_q + XLEN'(4);
   assign taken_c  = (a_q == b_q) ^ ir_q[12];
   assign busy_c   = (state_q != S_IDLE) && (state_q != S_HALT);

   // Instruction class, ALU operation and immediate from the held IR
   always_comb begin : decode
      cls_c    = C_ILLEGAL;
      alu_op_c = A_ADD;
      case (opcode)
         OP_STORE:  imm_c = imm_s;
         OP_BRANCH: imm_c = imm_b;
         default:   imm_c = imm_i;
      endcase
      if (ir_q == EBREAK) begin
         cls_c = C_EBREAK;
      end else begin
         case (opcode)
            OP_R: begin
               if (funct7 == 7'b0000000) begin
                  cls_c = C_ALU;
                  case (funct3)
                     3'b000:  alu_op_c = A_ADD;
                     3'b010:  alu_op_c = A_SLT;
                     3'b110:  alu_op_c = A_OR;
                     3'b111:  alu_op_c = A_AND;
                     default: cls_c    = C_ILLEGAL;
                  endcase
               end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                  cls_c    = C_ALU;
                  alu_op_c = A_SUB;
               end
            end
            OP_IMM:    if (funct3 == 3'b000)        cls_c = C_ADDI;
            OP_LOAD:   if (funct3 == LS_F3)         cls_c = C_LOAD;
            OP_STORE:  if (funct3 == LS_F3)         cls_c = C_STORE;
            OP_BRANCH: if (funct3[2:1] == 2'b00)    cls_c = C_BRANCH;
            default:   cls_c = C_ILLEGAL;
         endcase
      end
   end

   always_comb begin : alu
      op_b = (cls_c == C_ALU) ? b_q : imm_q;
      case (alu_op_c)
         A_SUB:   alu_res = a_q - op_b;
         A_AND:   alu_res = a_q & op_b;
         A_OR:    alu_res = a_q | op_b;
         A_SLT:   alu_res = XLEN'($signed(a_q) < $signed(op_b));
         default: alu_res = a_q + op_b;
      endcase
   end

   always_ff @(posedge clk) begin : state_reg
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin : next_state
      state_d   = state_q;
      retired_c = 1'b0;
      case (state_q)
         S_IDLE, S_HALT: if (bus_io.start) state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            if (cls_c == C_EBREAK) begin
               state_d   = S_HALT;
               retired_c = 1'b1;
            end else if (cls_c == C_ILLEGAL) begin
               state_d = S_HALT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (cls_c == C_BRANCH) begin
               state_d   = S_FETCH;
               retired_c = 1'b1;
            end else if (cls_c == C_LOAD || cls_c == C_STORE) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (cls_c == C_STORE) begin
               state_d   = S_FETCH;
               retired_c = 1'b1;
            end else begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            state_d   = S_FETCH;
            retired_c = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath registers and register file; one stage of work per state
   always_ff @(posedge clk) begin : datapath
      if (rst) begin
         pc_q      <= '0;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         imm_q     <= '0;
         alu_q     <= '0;
         mdr_q     <= '0;
         illegal_q <= 1'b0;
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_HALT: begin
               if (bus_io.start) begin
                  pc_q      <= '0;
                  illegal_q <= 1'b0;
               end
            end
            S_FETCH: ir_q <= imem_q[pc_q[2 +: IAW]];
            S_DECODE: begin
               a_q   <= rs1_val;
               b_q   <= rs2_val;
               imm_q <= imm_c;
               if (cls_c == C_ILLEGAL) illegal_q <= 1'b1;
            end
            S_EXEC: begin
               alu_q <= alu_res;
               if (cls_c == C_BRANCH) pc_q <= taken_c ? (pc_q + imm_q) : pc_plus4;
            end
            S_MEM: begin
               if (cls_c == C_LOAD)  mdr_q <= dmem_q[alu_q[BOFF +: DAW]];
               if (cls_c == C_STORE) pc_q  <= pc_plus4;
            end
            S_WB: begin
               if (rd != 5'd0) rf_q[rd] <= (cls_c == C_LOAD) ? mdr_q : alu_q;
               pc_q <= pc_plus4;
            end
            default: ;
         endcase
      end
   end

   // Memories are not reset; reset still blocks any write on its edge
   always_ff @(posedge clk) begin : mem_write
      if (!rst && bus_io.imem_we && !busy_c) imem_q[bus_io.imem_addr] <= bus_io.imem_wdata;
      if (!rst && state_q == S_MEM && cls_c == C_STORE) dmem_q[alu_q[BOFF +: DAW]] <= b_q;
   end

   assign bus_io.dbg_reg_data = (bus_io.dbg_reg_addr == 5'd0) ? '0 : rf_q[bus_io.dbg_reg_addr];
   assign bus_io.dbg_mem_data = dmem_q[bus_io.dbg_mem_addr];
   assign bus_io.busy         = busy_c;
   assign bus_io.halted       = (state_q == S_HALT);
   assign bus_io.illegal      = illegal_q;
   assign bus_io.retired      = retired_c;
   assign bus_io.pc_out       = pc_q;

`ifdef MULTI_CYCLE_CORE_TRACE_EN
   always @(posedge clk) begin
      if (!rst && retired_c)
         $display("retire pc=%h ir=%h x0=0 x1=%h x2=%h x3=%h x4=%h x5=%h x6=%h x7=%h x8=%h x9=%h",
                  pc_q, ir_q, rf_q[1], rf_q[2], rf_q[3], rf_q[4], rf_q[5],
                  rf_q[6], rf_q[7], rf_q[8], rf_q[9]);
   end
`else
`endif

endmodule
